// File: rtl/garage_door_plant.sv
// ----------------------------------------------------------------------------
// garage_door_plant
//   Behavioural, synthesisable model of garage door mechanics and limit
//   switches. It is the plant that a door controller drives: it takes the
//   motor commands and produces the limit-switch inputs. Door travel takes
//   real time, so controller benches and FPGA demos see realistic behaviour.
//
// Parameters
//   TRAVEL_STEPS : position steps from closed (0) to open (TRAVEL_STEPS),
//                  2..2^POS_W-1
//   STEP_CYCLES  : clock cycles of continuous drive per position step, 1..255
//   POS_W        : width of Position
//
// Ports
//   CLK      in   system clock, rising edge
//   RST      in   asynchronous active-low reset
//   UP_M     in   motor-up command
//   DN_M     in   motor-down command
//   UP_Max   out  upper limit switch (Position == TRAVEL_STEPS)
//   DN_Max   out  lower limit switch (Position == 0)
//   Position out  current door position, 0 = closed
//   Moving   out  door is opening or closing
//   Fault    out  sticky illegal-command flag (UP_M and DN_M both high)
//
// Every output is decoded from registered state only, so the plant never
// forms a combinational loop with the controller.
// ----------------------------------------------------------------------------
module garage_door_plant #(
    parameter int TRAVEL_STEPS = 8,
    parameter int STEP_CYCLES  = 2,
    parameter int POS_W        = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             UP_M,
    input  logic             DN_M,
    output logic             UP_Max,
    output logic             DN_Max,
    output logic [POS_W-1:0] Position,
    output logic             Moving,
    output logic             Fault
);

    localparam logic [2:0] S_CLOSED  = 3'd0;
    localparam logic [2:0] S_OPEN    = 3'd1;
    localparam logic [2:0] S_HALTED  = 3'd2;
    localparam logic [2:0] S_OPENING = 3'd3;
    localparam logic [2:0] S_CLOSING = 3'd4;
    localparam logic [2:0] S_FAULT   = 3'd5;

    localparam logic [POS_W-1:0] POS_TOP    = POS_W'(TRAVEL_STEPS);
    localparam logic [7:0]       PRESC_LAST = 8'(STEP_CYCLES - 1);

    logic [2:0]       state, state_nxt;
    logic [POS_W-1:0] pos, pos_nxt;
    logic [POS_W-1:0] pos_inc, pos_dec;
    logic [7:0]       presc, presc_nxt;
    logic [7:0]       presc_base;

    assign pos_inc = pos + 1'b1;
    assign pos_dec = pos - 1'b1;

    always_comb begin
        state_nxt  = state;
        pos_nxt    = pos;
        presc_nxt  = 8'd0;   // any edge without a continuing drive drops the partial step
        presc_base = 8'd0;
        if (state == S_FAULT) begin
            // Frozen until reset; commands ignored.
            state_nxt = S_FAULT;
        end else if (UP_M && DN_M) begin
            state_nxt = S_FAULT;
        end else if (UP_M) begin
            if (pos == POS_TOP) begin
                state_nxt = S_OPEN;  // overdrive into the limit is harmless
            end else begin
                // A fresh or reversed drive starts counting from zero; the
                // sampling edge itself is the first counted cycle.
                presc_base = (state == S_OPENING) ? presc : 8'd0;
                if (presc_base == PRESC_LAST) begin
                    pos_nxt   = pos_inc;
                    state_nxt = (pos_inc == POS_TOP) ? S_OPEN : S_OPENING;
                end else begin
                    presc_nxt = presc_base + 8'd1;
                    state_nxt = S_OPENING;
                end
            end
        end else if (DN_M) begin
            if (pos == '0) begin
                state_nxt = S_CLOSED;
            end else begin
                presc_base = (state == S_CLOSING) ? presc : 8'd0;
                if (presc_base == PRESC_LAST) begin
                    pos_nxt   = pos_dec;
                    state_nxt = (pos_dec == '0) ? S_CLOSED : S_CLOSING;
                end else begin
                    presc_nxt = presc_base + 8'd1;
                    state_nxt = S_CLOSING;
                end
            end
        end else begin
            if (pos == '0)          state_nxt = S_CLOSED;
            else if (pos == POS_TOP) state_nxt = S_OPEN;
            else                     state_nxt = S_HALTED;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= S_CLOSED;
            pos   <= '0;
            presc <= 8'd0;
        end else begin
            state <= state_nxt;
            pos   <= pos_nxt;
            presc <= presc_nxt;
        end
    end

    assign Position = pos;
    assign UP_Max   = (pos == POS_TOP);
    assign DN_Max   = (pos == '0);
    assign Moving   = (state == S_OPENING) || (state == S_CLOSING);
    assign Fault    = (state == S_FAULT);

endmodule
